// File: rtl/bias_pkg.sv
// bias_pkg: the layer type codes, the fetch FSM state encoding and the beat
// geometry shared by bias_fetch_sched and bias_credit_cnt.
package bias_pkg;

   typedef enum logic [2:0] {
      LT_CONV  = 3'd0,
      LT_DW    = 3'd1,
      LT_PW    = 3'd2,
      LT_AVGPL = 3'd3,
      LT_PW_SC = 3'd4
   } layer_type_e;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_CALC       = 3'd1,
      ST_WAIT_SPACE = 3'd2,
      ST_REQ        = 3'd3,
      ST_WAIT_DATA  = 3'd4,
      ST_DONE       = 3'd5
   } fetch_state_e;

   // One returned beat is 128 bits.
   localparam int unsigned BEAT_BYTES = 16;
   localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

   // The largest beat total is ceil(2047/16)*4 = 512, so 10 bits are enough.
   localparam int BEAT_CW = 10;

   // Width of the rd_len field and of the per-burst word count.
   localparam int LEN_W = 8;

endpackage

// File: rtl/bias_credit_cnt.sv
// bias_credit_cnt: tracks the bias FIFO words that have been requested from
// memory but are not yet written into the FIFO. It flags whether the next
// burst fits in the FIFO.
//   clk_200M, rst_n : clock, asynchronous active-low reset
//   add_words       : words added on the request accept cycle (0 otherwise)
//   dec             : one word written to the FIFO (fifo_wr_en)
//   fifo_cnt        : current FIFO occupancy
//   req_words       : words the pending burst will produce
//   inflight        : outstanding word count
//   space_ok        : FIFO_DEPTH - fifo_cnt - inflight >= req_words (signed)
module bias_credit_cnt
   import bias_pkg::*;
#(
   parameter int FIFO_DEPTH = 32,
   parameter int FIFO_CW    = 6
) (
   input  logic               clk_200M,
   input  logic               rst_n,
   input  logic [LEN_W-1:0]   add_words,
   input  logic               dec,
   input  logic [FIFO_CW-1:0] fifo_cnt,
   input  logic [LEN_W-1:0]   req_words,
   output logic [FIFO_CW:0]   inflight,
   output logic               space_ok
);

   localparam int ICW = FIFO_CW + 1;
   localparam int SW  = FIFO_CW + LEN_W + 2;

   logic [ICW-1:0]       sum;
   logic [ICW-1:0]       inflight_nxt;
   logic signed [SW-1:0] free_words;

   // A burst is admitted only when it fits within FIFO_DEPTH, and
   // FIFO_DEPTH < 2^FIFO_CW. An accepted add therefore always fits in ICW bits.
   always_comb begin
      sum          = inflight + ICW'(add_words);
      inflight_nxt = sum;
      // A write strobe with nothing outstanding is ignored.
      if (dec && (sum != '0)) begin
         inflight_nxt = sum - ICW'(1);
      end
   end

   always_comb begin
      free_words = SW'(FIFO_DEPTH) - SW'(fifo_cnt) - SW'(inflight);
      space_ok   = (free_words >= $signed(SW'(req_words)));
   end

   always_ff @(posedge clk_200M or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
      end else begin
         inflight <= inflight_nxt;
      end
   end

endmodule

// File: rtl/bias_fetch_sched.sv
// bias_fetch_sched: per-layer bias fetch scheduler. On layer_start it works out
// the number of 128-bit bias beats the layer needs. It splits them into bursts
// of at most BURST_BEATS and issues each burst to the DMA only when the
// 512-bit bias FIFO can hold every word that burst will produce.
//   clk_200M, rst_n          : clock, asynchronous active-low reset
//   layer_start, layer_type,
//   c_size, bias_base_addr   : layer command (sampled in IDLE only)
//   rd_req/rd_addr/rd_len,
//   rd_ack                   : DMA read request handshake
//   bias_in_vld              : returned beat strobe (monitored)
//   fifo_wr_en, fifo_cnt     : bias FIFO write strobe and occupancy (monitored)
//   busy, layer_done,
//   start_err                : status
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for layer_start
// CALC        | size the next burst from the remaining beats
// WAIT_SPACE  | hold until the FIFO has room for the burst's words
// REQ         | rd_req high until the DMA accepts
// WAIT_DATA   | count returned beats of the outstanding burst
// DONE        | layer_done pulse, then back to IDLE
module bias_fetch_sched
   import bias_pkg::*;
#(
   parameter int BURST_BEATS = 16,
   parameter int FIFO_DEPTH  = 32,
   parameter int FIFO_CW     = 6
) (
   input  logic               clk_200M,
   input  logic               rst_n,
   input  logic               layer_start,
   input  logic [2:0]         layer_type,
   input  logic [10:0]        c_size,
   input  logic [31:0]        bias_base_addr,
   output logic               rd_req,
   output logic [31:0]        rd_addr,
   output logic [LEN_W-1:0]   rd_len,
   input  logic               rd_ack,
   input  logic               bias_in_vld,
   input  logic               fifo_wr_en,
   input  logic [FIFO_CW-1:0] fifo_cnt,
   output logic               busy,
   output logic               layer_done,
   output logic               start_err
);

   fetch_state_e        state;
   fetch_state_e        nxt;

   logic                is_dw_q;
   logic [BEAT_CW-1:0]  remaining_q;
   logic [LEN_W-1:0]    beat_left_q;

   logic [11:0]         ch_pad;
   logic [11:0]         ch_dw;
   logic [BEAT_CW-1:0]  beat_total;
   logic [LEN_W-1:0]    len_next;
   logic [LEN_W-1:0]    burst_words;
   logic [LEN_W-1:0]    add_words;
   logic                accept;
   logic                burst_last;
   logic                space_ok;
   logic [FIFO_CW:0]    inflight;

   // CONV/PW fetch whole 16-channel groups (4 beats each). DW packs 4
   // channels per beat.
   always_comb begin
      ch_pad     = {1'b0, c_size} + 12'd15;
      ch_dw      = {1'b0, c_size} + 12'd3;
      beat_total = '0;
      case (layer_type)
         LT_CONV, LT_PW, LT_PW_SC: beat_total = BEAT_CW'((ch_pad >> 4) << 2);
         LT_DW:                    beat_total = BEAT_CW'(ch_dw >> 2);
         default:                  beat_total = '0;
      endcase
   end

   always_comb begin
      len_next    = (remaining_q > BEAT_CW'(BURST_BEATS)) ? LEN_W'(BURST_BEATS)
                                                         : remaining_q[LEN_W-1:0];
      burst_words = is_dw_q ? rd_len : {2'b00, rd_len[LEN_W-1:2]};
      accept      = rd_req && rd_ack;
      add_words   = accept ? burst_words : '0;
      // A zero-length burst (empty layer) completes without waiting for any beat.
      burst_last  = (beat_left_q == '0) || (bias_in_vld && (beat_left_q == LEN_W'(1)));
   end

   bias_credit_cnt #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .FIFO_CW    (FIFO_CW)
   ) u_credit (
      .clk_200M  (clk_200M),
      .rst_n     (rst_n),
      .add_words (add_words),
      .dec       (fifo_wr_en),
      .fifo_cnt  (fifo_cnt),
      .req_words (burst_words),
      .inflight  (inflight),
      .space_ok  (space_ok)
   );

   always_ff @(posedge clk_200M or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt;
      end
   end

   // An empty layer goes CALC -> WAIT_DATA with a zero-length burst. It then
   // passes through DONE on the usual path and issues no request.
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:       if (layer_start) nxt = ST_CALC;
         ST_CALC:       nxt = (remaining_q == '0) ? ST_WAIT_DATA : ST_WAIT_SPACE;
         ST_WAIT_SPACE: if (space_ok) nxt = ST_REQ;
         ST_REQ:        if (rd_ack) nxt = ST_WAIT_DATA;
         ST_WAIT_DATA:  if (burst_last) nxt = (remaining_q == '0) ? ST_DONE : ST_CALC;
         ST_DONE:       nxt = ST_IDLE;
         default:       nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_200M or negedge rst_n) begin
      if (!rst_n) begin
         is_dw_q     <= 1'b0;
         remaining_q <= '0;
         beat_left_q <= '0;
         rd_addr     <= '0;
         rd_len      <= '0;
         rd_req      <= 1'b0;
         busy        <= 1'b0;
         layer_done  <= 1'b0;
         start_err   <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && layer_start) begin
            is_dw_q     <= (layer_type == LT_DW);
            remaining_q <= beat_total;
            rd_addr     <= bias_base_addr;
         end
         // remaining_q already excludes the burst in flight, so WAIT_DATA
         // can test it directly for the last burst.
         if (state == ST_CALC) begin
            rd_len      <= len_next;
            beat_left_q <= len_next;
            remaining_q <= remaining_q - BEAT_CW'(len_next);
         end
         if (accept) begin
            rd_addr <= rd_addr + (32'(rd_len) << BEAT_SHIFT);
         end
         if ((state == ST_WAIT_DATA) && bias_in_vld && (beat_left_q != '0)) begin
            beat_left_q <= beat_left_q - LEN_W'(1);
         end
         rd_req     <= (nxt == ST_REQ);
         busy       <= (nxt != ST_IDLE);
         layer_done <= (nxt == ST_DONE);
         start_err  <= layer_start && (state != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_bias_fetch_sched.sv
`timescale 1ns/1ps
module tb_bias_fetch_sched;

   logic        clk_200M = 1'b0;
   logic        rst_n;
   logic        layer_start;
   logic [2:0]  layer_type;
   logic [10:0] c_size;
   logic [31:0] bias_base_addr;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic [7:0]  rd_len;
   logic        rd_ack;
   logic        bias_in_vld;
   logic        fifo_wr_en;
   logic [5:0]  fifo_cnt;
   logic        busy;
   logic        layer_done;
   logic        start_err;

   int vec_cnt   = 0;
   int miss_cnt  = 0;
   int done_seen = 0;
   int req_seen  = 0;

   always #2.5 clk_200M = ~clk_200M;

   bias_fetch_sched #(
      .BURST_BEATS (16),
      .FIFO_DEPTH  (32),
      .FIFO_CW     (6)
   ) dut (
      .clk_200M       (clk_200M),
      .rst_n          (rst_n),
      .layer_start    (layer_start),
      .layer_type     (layer_type),
      .c_size         (c_size),
      .bias_base_addr (bias_base_addr),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_len         (rd_len),
      .rd_ack         (rd_ack),
      .bias_in_vld    (bias_in_vld),
      .fifo_wr_en     (fifo_wr_en),
      .fifo_cnt       (fifo_cnt),
      .busy           (busy),
      .layer_done     (layer_done),
      .start_err      (start_err)
   );

   task automatic tick();
      @(posedge clk_200M);
      #1;
      if (layer_done === 1'b1) done_seen++;
      if (rd_req === 1'b1) req_seen++;
   endtask

   task automatic wait_req(input int limit, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      while (!ok && (n < limit)) begin
         tick();
         n++;
         if (rd_req === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic start_layer(input logic [2:0] lt, input logic [10:0] cs, input logic [31:0] base);
      layer_type     = lt;
      c_size         = cs;
      bias_base_addr = base;
      layer_start    = 1'b1;
      tick();
      layer_start    = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      vec_cnt++;
      if ({rd_req, rd_addr, rd_len, busy, layer_done, start_err} !== 44'd0)
         $display("FAIL reset_outputs: got req=%b addr=%h len=%0d busy=%b done=%b err=%b expected all 0",
                  rd_req, rd_addr, rd_len, busy, layer_done, start_err);
      vec_cnt++;
      if (dut.inflight !== 7'd0) begin
         miss_cnt++;
         $display("FAIL reset_inflight: got %0d expected 0", dut.inflight);
      end
      if ({rd_req, rd_addr, rd_len, busy, layer_done, start_err} !== 44'd0) miss_cnt++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_conv();
      bit ok;
      int n;
      done_seen = 0;
      start_layer(3'd0, 11'd32, 32'h1000);
      vec_cnt++;
      if (busy !== 1'b1) begin miss_cnt++; $display("FAIL conv_busy: got %b expected 1", busy); end
      wait_req(10, ok, n);
      vec_cnt++;
      if (!ok || n != 2) begin miss_cnt++; $display("FAIL conv_req_latency: seen=%0d after %0d cycles expected 1 after 2", ok, n); end
      vec_cnt++;
      if (rd_addr !== 32'h1000) begin miss_cnt++; $display("FAIL conv_addr: got %h expected 00001000", rd_addr); end
      vec_cnt++;
      if (rd_len !== 8'd8) begin miss_cnt++; $display("FAIL conv_len: got %0d expected 8", rd_len); end
      tick();
      vec_cnt++;
      if (rd_req !== 1'b0) begin miss_cnt++; $display("FAIL conv_req_drop: got %b expected 0", rd_req); end
      vec_cnt++;
      if (dut.inflight !== 7'd2) begin miss_cnt++; $display("FAIL conv_inflight: got %0d expected 2", dut.inflight); end
      for (int i = 0; i < 8; i++) begin
         bias_in_vld = 1'b1;
         tick();
         if (i == 6) begin
            vec_cnt++;
            if (layer_done !== 1'b0) begin miss_cnt++; $display("FAIL conv_done_early: got %b expected 0", layer_done); end
         end
      end
      bias_in_vld = 1'b0;
      vec_cnt++;
      if (layer_done !== 1'b1) begin miss_cnt++; $display("FAIL conv_done: got %b expected 1", layer_done); end
      tick();
      vec_cnt++;
      if ({busy, layer_done} !== 2'b00) begin miss_cnt++; $display("FAIL conv_idle: got busy=%b done=%b expected 0 0", busy, layer_done); end
      vec_cnt++;
      if (dut.inflight !== 7'd2) begin miss_cnt++; $display("FAIL conv_inflight_hold: got %0d expected 2", dut.inflight); end
      for (int i = 0; i < 2; i++) begin
         fifo_wr_en = 1'b1;
         tick();
         fifo_wr_en = 1'b0;
         vec_cnt++;
         if (dut.inflight !== 7'(1 - i)) begin miss_cnt++; $display("FAIL conv_drain: got %0d expected %0d", dut.inflight, 1 - i); end
      end
   endtask

   task automatic test_dw();
      bit ok;
      int n;
      start_layer(3'd1, 11'd32, 32'h2000);
      wait_req(10, ok, n);
      vec_cnt++;
      if (!ok || rd_len !== 8'd8 || rd_addr !== 32'h2000) begin
         miss_cnt++;
         $display("FAIL dw_req: got seen=%0d len=%0d addr=%h expected 1 8 00002000", ok, rd_len, rd_addr);
      end
      tick();
      vec_cnt++;
      if (dut.inflight !== 7'd8) begin miss_cnt++; $display("FAIL dw_inflight: got %0d expected 8", dut.inflight); end
      for (int i = 0; i < 8; i++) begin bias_in_vld = 1'b1; tick(); end
      bias_in_vld = 1'b0;
      vec_cnt++;
      if (layer_done !== 1'b1) begin miss_cnt++; $display("FAIL dw_done: got %b expected 1", layer_done); end
      for (int i = 0; i < 8; i++) begin fifo_wr_en = 1'b1; tick(); end
      fifo_wr_en = 1'b0;
      vec_cnt++;
      if (dut.inflight !== 7'd0) begin miss_cnt++; $display("FAIL dw_drain: got %0d expected 0", dut.inflight); end
   endtask

   task automatic test_rounding();
      bit ok;
      int n;
      logic [2:0]  t_type  [3] = '{3'd1, 3'd0, 3'd4};
      logic [10:0] t_c     [3] = '{11'd5, 11'd1, 11'd17};
      logic [7:0]  t_len   [3] = '{8'd2, 8'd4, 8'd8};
      logic [6:0]  t_words [3] = '{7'd2, 7'd1, 7'd2};
      for (int k = 0; k < 3; k++) begin
         start_layer(t_type[k], t_c[k], 32'h0000_0400);
         wait_req(10, ok, n);
         vec_cnt++;
         if (!ok || rd_len !== t_len[k]) begin miss_cnt++; $display("FAIL round_len[%0d]: got seen=%0d len=%0d expected len %0d", k, ok, rd_len, t_len[k]); end
         tick();
         vec_cnt++;
         if (dut.inflight !== t_words[k]) begin miss_cnt++; $display("FAIL round_words[%0d]: got %0d expected %0d", k, dut.inflight, t_words[k]); end
         for (int i = 0; i < int'(t_len[k]); i++) begin bias_in_vld = 1'b1; tick(); end
         bias_in_vld = 1'b0;
         vec_cnt++;
         if (layer_done !== 1'b1) begin miss_cnt++; $display("FAIL round_done[%0d]: got %b expected 1", k, layer_done); end
         for (int i = 0; i < int'(t_words[k]); i++) begin fifo_wr_en = 1'b1; tick(); end
         fifo_wr_en = 1'b0;
         tick();
      end
   endtask

   task automatic test_pw_multi();
      bit   ok;
      int   n;
      int   exp_len;
      logic [31:0] exp_addr;
      done_seen = 0;
      req_seen  = 0;
      start_layer(3'd2, 11'd1001, 32'h4000);
      for (int b = 0; b < 16; b++) begin
         exp_len  = (b == 15) ? 12 : 16;
         exp_addr = 32'h4000 + 32'(b) * 32'h100;
         wait_req(12, ok, n);
         vec_cnt++;
         if (!ok) begin miss_cnt++; $display("FAIL pw_req_timeout[%0d]: got no rd_req expected one", b); end
         vec_cnt++;
         if (rd_addr !== exp_addr) begin miss_cnt++; $display("FAIL pw_addr[%0d]: got %h expected %h", b, rd_addr, exp_addr); end
         vec_cnt++;
         if (rd_len !== 8'(exp_len)) begin miss_cnt++; $display("FAIL pw_len[%0d]: got %0d expected %0d", b, rd_len, exp_len); end
         tick();
         for (int i = 0; i < exp_len; i++) begin
            bias_in_vld = 1'b1;
            fifo_wr_en  = ((i % 4) == 3);
            tick();
         end
         bias_in_vld = 1'b0;
         fifo_wr_en  = 1'b0;
      end
      vec_cnt++;
      if (layer_done !== 1'b1) begin miss_cnt++; $display("FAIL pw_done: got %b expected 1", layer_done); end
      tick();
      tick();
      vec_cnt++;
      if (done_seen != 1) begin miss_cnt++; $display("FAIL pw_done_count: got %0d expected 1", done_seen); end
      vec_cnt++;
      if (req_seen != 16) begin miss_cnt++; $display("FAIL pw_req_count: got %0d expected 16", req_seen); end
      vec_cnt++;
      if (busy !== 1'b0 || dut.inflight !== 7'd0) begin miss_cnt++; $display("FAIL pw_end: got busy=%b inflight=%0d expected 0 0", busy, dut.inflight); end
   endtask

   task automatic test_avgpl();
      done_seen = 0;
      req_seen  = 0;
      start_layer(3'd3, 11'd64, 32'h6000);
      vec_cnt++;
      if (busy !== 1'b1) begin miss_cnt++; $display("FAIL avg_busy: got %b expected 1", busy); end
      // A stray CONV start while busy must be flagged and otherwise ignored.
      layer_type  = 3'd0;
      layer_start = 1'b1;
      tick();
      layer_start = 1'b0;
      vec_cnt++;
      if (start_err !== 1'b1) begin miss_cnt++; $display("FAIL avg_start_err: got %b expected 1", start_err); end
      vec_cnt++;
      if (layer_done !== 1'b0) begin miss_cnt++; $display("FAIL avg_done_early: got %b expected 0", layer_done); end
      tick();
      vec_cnt++;
      if ({layer_done, start_err, busy} !== 3'b101) begin miss_cnt++; $display("FAIL avg_done: got done=%b err=%b busy=%b expected 1 0 1", layer_done, start_err, busy); end
      tick();
      vec_cnt++;
      if ({busy, layer_done} !== 2'b00) begin miss_cnt++; $display("FAIL avg_idle: got busy=%b done=%b expected 0 0", busy, layer_done); end
      for (int i = 0; i < 4; i++) tick();
      vec_cnt++;
      if (req_seen != 0 || done_seen != 1 || busy !== 1'b0) begin
         miss_cnt++;
         $display("FAIL avg_no_req: got reqs=%0d dones=%0d busy=%b expected 0 1 0", req_seen, done_seen, busy);
      end
   endtask

   task automatic test_space_stall();
      bit ok;
      req_seen = 0;
      fifo_cnt = 6'd20;
      start_layer(3'd1, 11'd64, 32'h8000);
      for (int i = 0; i < 6; i++) tick();
      vec_cnt++;
      if (req_seen != 0 || busy !== 1'b1) begin miss_cnt++; $display("FAIL stall_hold: got reqs=%0d busy=%b expected 0 1", req_seen, busy); end
      fifo_cnt = 6'd16;
      ok = 1'b0;
      for (int i = 0; (i < 2) && !ok; i++) begin
         tick();
         if (rd_req === 1'b1) ok = 1'b1;
      end
      vec_cnt++;
      if (!ok || rd_len !== 8'd16) begin miss_cnt++; $display("FAIL stall_release: got seen=%0d len=%0d expected 1 16", ok, rd_len); end
      fifo_wr_en = 1'b1;
      tick();
      fifo_wr_en = 1'b0;
      fifo_cnt   = 6'd0;
      vec_cnt++;
      if (dut.inflight !== 7'd15) begin miss_cnt++; $display("FAIL stall_net_update: got %0d expected 15", dut.inflight); end
      for (int i = 0; i < 16; i++) begin bias_in_vld = 1'b1; tick(); end
      bias_in_vld = 1'b0;
      vec_cnt++;
      if (layer_done !== 1'b1) begin miss_cnt++; $display("FAIL stall_done: got %b expected 1", layer_done); end
      for (int i = 0; i < 15; i++) begin fifo_wr_en = 1'b1; tick(); end
      vec_cnt++;
      if (dut.inflight !== 7'd0) begin miss_cnt++; $display("FAIL stall_drain: got %0d expected 0", dut.inflight); end
      tick();
      fifo_wr_en = 1'b0;
      vec_cnt++;
      if (dut.inflight !== 7'd0) begin miss_cnt++; $display("FAIL stall_saturate: got %0d expected 0", dut.inflight); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      start_layer(3'd0, 11'd16, 32'h5000);
      wait_req(10, ok, n);
      tick();
      for (int i = 0; i < 2; i++) begin bias_in_vld = 1'b1; tick(); end
      bias_in_vld = 1'b0;
      vec_cnt++;
      if (busy !== 1'b1 || rd_addr !== 32'h5040) begin miss_cnt++; $display("FAIL mid_pre: got busy=%b addr=%h expected 1 00005040", busy, rd_addr); end
      #1 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({rd_req, rd_addr, rd_len, busy, layer_done, start_err} !== 44'd0 || dut.inflight !== 7'd0) begin
         miss_cnt++;
         $display("FAIL mid_async_reset: got req=%b addr=%h len=%0d busy=%b inflight=%0d expected all 0", rd_req, rd_addr, rd_len, busy, dut.inflight);
      end
      done_seen = 0;
      tick();
      rst_n = 1'b1;
      tick();
      vec_cnt++;
      if (done_seen != 0) begin miss_cnt++; $display("FAIL mid_partial_done: got %0d expected 0", done_seen); end
      start_layer(3'd0, 11'd20, 32'h3000);
      wait_req(10, ok, n);
      vec_cnt++;
      if (!ok || n != 2 || rd_addr !== 32'h3000 || rd_len !== 8'd8) begin
         miss_cnt++;
         $display("FAIL mid_fresh_req: got seen=%0d cyc=%0d addr=%h len=%0d expected 1 2 00003000 8", ok, n, rd_addr, rd_len);
      end
      tick();
      for (int i = 0; i < 8; i++) begin bias_in_vld = 1'b1; tick(); end
      bias_in_vld = 1'b0;
      vec_cnt++;
      if (layer_done !== 1'b1) begin miss_cnt++; $display("FAIL mid_fresh_done: got %b expected 1", layer_done); end
      for (int i = 0; i < 2; i++) begin fifo_wr_en = 1'b1; tick(); end
      fifo_wr_en = 1'b0;
      tick();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n          = 1'b0;
      layer_start    = 1'b0;
      layer_type     = 3'd0;
      c_size         = 11'd0;
      bias_base_addr = 32'd0;
      rd_ack         = 1'b1;
      bias_in_vld    = 1'b0;
      fifo_wr_en     = 1'b0;
      fifo_cnt       = 6'd0;
      test_reset();
      test_conv();
      test_dw();
      test_rounding();
      test_pw_multi();
      test_avgpl();
      test_space_stall();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
